fetch_pc_unit: RTL

Fetch-side owner of the program counter. It consumes the redirect stream produced by the execute-stage branch/jump target logic (taken flag, target address, target error), sequences the PC, and drives fetch valid, pipeline flush, halt and error status. It sits between the execute-stage control path and the instruction-memory address port.

---
 rtl/fetch_pc_unit_pkg.sv | 57 +++++
 rtl/fetch_pc_unit_if.sv | 36 +++
 rtl/fetch_pc_unit_redirect_buf.sv | 47 ++++
 rtl/fetch_pc_unit.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pc_unit_pkg
// Shared definitions for the fetch PC unit:
//   - fsm_state_t : 2-bit FSM state encoding (BOOT, RUN, HALTED, FAULT)
//   - RESET_PC_DEFAULT, INSTR_BYTES_DEFAULT : parameter defaults for the top
//   - cla_add16() : 16-bit carry-lookahead adder (4-bit groups), wraps mod 2^16
// Optional feature macro used by the importing files: FETCH_REDIRECT_BUF_EN
// ----------------------------------------------------------------------------
package fetch_pc_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } fsm_state_t;

    localparam logic [15:0] RESET_PC_DEFAULT    = 16'h0000;
    localparam logic [15:0] INSTR_BYTES_DEFAULT = 16'd2;

    // Four 4-bit groups; each group produces a group generate/propagate pair
    // so the carry into the next group does not ripple through its bits.
    // Carry out of bit 15 is dropped, giving modulo-2^16 wrap.
    function automatic logic [15:0] cla_add16(input logic [15:0] a,
                                              input logic [15:0] b);
        logic [15:0] g;
        logic [15:0] p;
        logic [15:0] sum;
        logic [3:0]  gc;
        logic        c;
        logic        grp_g;
        logic        grp_p;
        g     = a & b;
        p     = a ^ b;
        sum   = '0;
        gc    = '0;
        c     = 1'b0;
        grp_g = 1'b0;
        grp_p = 1'b1;
        for (int k = 0; k < 4; k++) begin
            c     = gc[k];
            grp_g = 1'b0;
            grp_p = 1'b1;
            for (int i = 0; i < 4; i++) begin
                sum[4*k+i] = p[4*k+i] ^ c;
                c          = g[4*k+i] | (p[4*k+i] & c);
                grp_g      = g[4*k+i] | (p[4*k+i] & grp_g);
                grp_p      = grp_p & p[4*k+i];
            end
            if (k < 3) begin
                gc[k+1] = grp_g | (grp_p & gc[k]);
            end
        end
        return sum;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_pc_unit_if
// Bundles the execute-side control inputs and fetch-side status outputs of the
// fetch PC unit.
//   master (execute/decode side): drives stall, redirect_valid, redirect_addr,
//                                 target_err, halt; observes the outputs
//   slave  (fetch_pc_unit)      : drives pc, pc_next_seq, fetch_valid, flush,
//                                 halted, err
// Signalling: redirect_valid is a single-cycle request with no ready; it is
// consumed in the cycle it is high (or parked while stalled when the
// FETCH_REDIRECT_BUF_EN build is used). fetch_valid marks the address on pc as
// a live fetch in that cycle.
// ----------------------------------------------------------------------------
interface fetch_pc_unit_if;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        target_err;
    logic        halt;
    logic [15:0] pc;
    logic [15:0] pc_next_seq;
    logic        fetch_valid;
    logic        flush;
    logic        halted;
    logic        err;

    modport master (
        output stall, redirect_valid, redirect_addr, target_err, halt,
        input  pc, pc_next_seq, fetch_valid, flush, halted, err
    );

    modport slave (
        input  stall, redirect_valid, redirect_addr, target_err, halt,
        output pc, pc_next_seq, fetch_valid, flush, halted, err
    );
endinterface

// File: rtl/fetch_pc_unit_redirect_buf.sv
// ----------------------------------------------------------------------------
// fetch_pc_unit_redirect_buf
// One-entry pending redirect holder (valid bit + 16-bit target address).
// Only instantiated when FETCH_REDIRECT_BUF_EN is defined.
//   clk, rst  : clock, asynchronous active-high reset (clears entry)
//   load_i    : write addr_i and set valid (overwrites an older entry)
//   clear_i   : drop the entry (load_i wins if both are high)
//   addr_i    : target address to store
//   valid_o   : entry present
//   addr_o    : stored target address
// ----------------------------------------------------------------------------
module fetch_pc_unit_redirect_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [15:0] addr_i,
    output logic        valid_o,
    output logic [15:0] addr_o
);
    logic        valid_q, valid_d;
    logic [15:0] addr_q, addr_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (load_i) begin
            valid_d = 1'b1;
            addr_d  = addr_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= 16'h0000;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
endmodule

// File: rtl/fetch_pc_unit.sv
// ----------------------------------------------------------------------------
// fetch_pc_unit
// Owns the program counter: sequences it, applies execute-stage redirects,
// and reports fetch valid, IF/ID flush, halt and sticky fault status.
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   bus     : fetch_pc_unit_if.slave (stall, redirect_valid, redirect_addr,
//             target_err, halt in; pc, pc_next_seq, fetch_valid, flush,
//             halted, err out)
//   state_o : current FSM state (debug)
// Parameters: RESET_PC (PC after reset), INSTR_BYTES (sequential increment).
// Optional macro FETCH_REDIRECT_BUF_EN: a redirect arriving during a stall is
// parked in a one-entry buffer and applied on the first unstalled cycle.
// Without it a redirect overrides stall and loads the PC immediately.
// ----------------------------------------------------------------------------
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter logic [15:0] INSTR_BYTES = INSTR_BYTES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    fetch_pc_unit_if.slave    bus,
    output fsm_state_t        state_o
);
    fsm_state_t  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        halted_q, halted_d;
    logic        err_q, err_d;
    logic [15:0] pc_inc;
    logic        redirect_fault;

    assign pc_inc = cla_add16(pc_q, INSTR_BYTES);

    // Odd targets are misaligned; checked whenever a redirect is presented,
    // independent of stall.
    assign redirect_fault = bus.target_err |
                            (bus.redirect_valid & bus.redirect_addr[0]);

`ifdef FETCH_REDIRECT_BUF_EN
    logic        buf_load;
    logic        buf_clear;
    logic        buf_valid;
    logic [15:0] buf_addr;

    fetch_pc_unit_redirect_buf u_redirect_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .addr_i  (bus.redirect_addr),
        .valid_o (buf_valid),
        .addr_o  (buf_addr)
    );
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        flush_d  = 1'b0;
        halted_d = halted_q;
        err_d    = err_q;
`ifdef FETCH_REDIRECT_BUF_EN
        buf_load  = 1'b0;
        buf_clear = 1'b0;
`endif
        unique case (state_q)
            ST_BOOT: begin
                // pc already holds RESET_PC, so the first fetch is there.
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_fault) begin
                    state_d = ST_FAULT;
                    err_d   = 1'b1;
`ifdef FETCH_REDIRECT_BUF_EN
                end else if (bus.redirect_valid && bus.stall) begin
                    buf_load = 1'b1;
                end else if (bus.redirect_valid) begin
                    // A live redirect is newer than anything parked.
                    pc_d      = bus.redirect_addr;
                    flush_d   = 1'b1;
                    buf_clear = 1'b1;
                end else if (buf_valid && !bus.stall) begin
                    pc_d      = buf_addr;
                    flush_d   = 1'b1;
                    buf_clear = 1'b1;
                end else if (buf_valid) begin
                    // Waiting to apply a parked redirect; anything decoded
                    // meanwhile (including halt) lies in the squashed path.
                    pc_d = pc_q;
`else
                end else if (bus.redirect_valid) begin
                    pc_d    = bus.redirect_addr;
                    flush_d = 1'b1;
`endif
                end else if (bus.halt) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end else if (!bus.stall) begin
                    pc_d = pc_inc;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
                err_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_PC;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            flush_q  <= flush_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_next_seq = pc_inc;
    assign bus.fetch_valid = (state_q == ST_RUN) && !bus.stall;
    assign bus.flush       = flush_q;
    assign bus.halted      = halted_q;
    assign bus.err         = err_q;
    assign state_o         = state_q;
endmodule
